uart_rx_fifo: RTL and testbench

Serial receive front-end for the Bus: samples the Rx_Serial pin, deframes 8N1 UART characters and buffers received bytes in a small first-word-fall-through FIFO that the Bus reads as a peripheral. Sits directly between the board Rx_Serial pin and the Bus peripheral read mux. Default timing targets 9600 baud from the 100 MHz system clock.

---
 rtl/uart_rx_fifo.sv | 89 ++++++++
 tb/tb_uart_rx_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Rx_Serial,
    input  logic                   rd_en,
    input  logic                   clr_status,
    output logic [7:0]             rd_data,
    output logic                   rx_valid,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    state_t state, state_nxt;
    logic sync1, rxs;
    logic [CW-1:0] clk_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg, last_q;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic half_pt, end_pt, push_req, stop_bad, pop, wr, ovf;
    assign half_pt = clk_cnt == HALF_CNT;
    assign end_pt = clk_cnt == END_CNT;
    always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = rxs ? IDLE : START;
            START:     state_nxt = half_pt ? (rxs ? IDLE : DATA) : START;
            DATA:      state_nxt = (end_pt && bit_idx == 3'd7) ? STOP : DATA;
            STOP:      state_nxt = end_pt ? (rxs ? IDLE : WAIT_HIGH) : STOP;
            WAIT_HIGH: state_nxt = rxs ? IDLE : WAIT_HIGH;
            default:   state_nxt = IDLE;
        endcase
    end
    always_comb begin
        push_req = state == STOP && end_pt && rxs;
        stop_bad = state == STOP && end_pt && !rxs;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
        end else begin
            sync1 <= Rx_Serial;
            rxs <= sync1;
            clk_cnt <= (state == IDLE || state == WAIT_HIGH || (state == START && half_pt) || end_pt) ? '0 : clk_cnt + 1'b1;
            bit_idx <= state == START ? 3'd0 : (state == DATA && end_pt) ? bit_idx + 3'd1 : bit_idx;
            if (state == DATA && end_pt) shreg <= {rxs, shreg[7:1]};
        end
    end
    assign rx_valid = rx_count != '0;
    assign pop = rd_en && rx_valid;
    assign wr = push_req && (rx_count != FULL_CNT || pop);
    assign ovf = push_req && !wr;
    assign rd_data = rx_valid ? mem[rp] : last_q;
    always_ff @(posedge clk) if (wr) mem[wp] <= shreg;
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            rx_count <= '0;
            last_q <= '0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                last_q <= mem[rp];
            end
            rx_count <= rx_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
            frame_err <= stop_bad || (frame_err && !clr_status);
            overrun <= ovf || (overrun && !clr_status);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven and scoreboard checks of the UART receive FIFO
module tb_uart_rx_fifo;
    localparam int CPB = 16;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1, Rx_Serial = 1, rd_en = 0, clr_status = 0;
    logic [7:0] rd_data;
    logic rx_valid, frame_err, overrun;
    logic [2:0] rx_count;
    int checks = 0, failures = 0;
    logic [7:0] q[$];
    typedef struct {
        logic [7:0] d;
        int cnt;
        logic ovr;
    } vec_t;
    vec_t vecs[5];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .Rx_Serial(Rx_Serial), .rd_en(rd_en),
        .clr_status(clr_status), .rd_data(rd_data), .rx_valid(rx_valid),
        .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
        Rx_Serial = 0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx_Serial = d[i];
            repeat (CPB) @(negedge clk);
        end
        Rx_Serial = stop;
        repeat (CPB * (1 + (stop ? 0 : extra_low))) @(negedge clk);
        Rx_Serial = 1;
        repeat (2 * CPB) @(negedge clk);
        if (stop && q.size() < DEPTH) q.push_back(d);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        chk({name, "_valid"}, rx_valid, 1);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got %0h", name, rd_data);
        end else begin
            e = q.pop_front();
            chk(name, rd_data, e);
        end
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic pulse_clr();
        clr_status = 1;
        @(negedge clk);
        clr_status = 0;
    endtask

    initial begin
        logic [7:0] e;
        vecs[0] = '{8'h01, 1, 1'b0};
        vecs[1] = '{8'h02, 2, 1'b0};
        vecs[2] = '{8'h03, 3, 1'b0};
        vecs[3] = '{8'h04, 4, 1'b0};
        vecs[4] = '{8'h05, 4, 1'b1};
        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);

        send_frame(8'hA5, 1, 0);
        chk("a5_count", rx_count, 1);
        chk("a5_ferr", frame_err, 0);
        chk("a5_ovr", overrun, 0);
        pop_check("a5_data");
        chk("a5_empty", rx_valid, 0);
        chk("a5_count0", rx_count, 0);
        chk("a5_hold", rd_data, 8'hA5);

        Rx_Serial = 0;
        repeat (4) @(negedge clk);
        Rx_Serial = 1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_count", rx_count, 0);

        send_frame(8'h3C, 0, 2);
        chk("ferr_set", frame_err, 1);
        chk("ferr_nopush", rx_count, 0);
        send_frame(8'h11, 1, 0);
        chk("ferr_next_count", rx_count, 1);
        pop_check("ferr_next_data");
        pulse_clr();
        chk("ferr_clr", frame_err, 0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].d, 1, 0);
            chk($sformatf("tbl%0d_count", i), rx_count, vecs[i].cnt);
            chk($sformatf("tbl%0d_ovr", i), overrun, vecs[i].ovr);
        end
        for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
        chk("drain_empty", rx_valid, 0);
        pulse_clr();
        chk("ovr_clr", overrun, 0);

        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1, 0);
        chk("refill_count", rx_count, 4);
        fork
            send_frame(8'h55, 1, 0);
            begin
                repeat (154) @(negedge clk);
                e = q.pop_front();
                chk("same_cycle_head", rd_data, e);
                rd_en = 1;
                @(negedge clk);
                rd_en = 0;
            end
        join
        chk("same_cycle_count", rx_count, 4);
        chk("same_cycle_ovr", overrun, 0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("sc_drain%0d", i));
        chk("sc_empty", rx_valid, 0);

        send_frame(8'h42, 1, 0);
        send_frame(8'h00, 0, 1);
        chk("pre_rst_ferr", frame_err, 1);
        fork
            send_frame(8'hFF, 1, 0);
            begin
                repeat (80) @(negedge clk);
                reset = 1;
                @(negedge clk);
                reset = 0;
                chk("midrst_valid", rx_valid, 0);
                chk("midrst_count", rx_count, 0);
                chk("midrst_data", rd_data, 0);
                chk("midrst_ferr", frame_err, 0);
                chk("midrst_ovr", overrun, 0);
            end
        join
        q.delete();
        chk("midrst_nopush", rx_valid, 0);
        send_frame(8'h7E, 1, 0);
        chk("post_rst_count", rx_count, 1);
        pop_check("post_rst_data");
        chk("post_rst_empty", rx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
